// File: rtl/lc3_pc_unit.sv
// LC-3 program-counter stage: fetch increment plus BR/JMP/JSR/JSRR target
// resolution with an R7 link write, driven by a start/done handshake.
module lc3_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic [15:0] sext9,
    input  logic [15:0] sext11,
    input  logic [15:0] base_r,
    input  logic [2:0]  nzp,
    output logic [15:0] pc,
    output logic        busy,
    output logic        done,
    output logic        r7_we,
    output logic [15:0] r7_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_LINK,
        S_DONE
    } state_e;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    state_e      state_q,   state_d;
    logic [15:0] pc_q,      pc_d;
    logic [6:0]  ir_q,      ir_d;       // ir[15:9]: opcode plus cond / JSR-vs-JSRR bits
    logic [15:0] sext9_q,   sext9_d;
    logic [15:0] sext11_q,  sext11_d;
    logic [15:0] base_r_q,  base_r_d;
    logic [2:0]  nzp_q,     nzp_d;
    logic [15:0] link_pc_q, link_pc_d;
    logic [15:0] target_q,  target_d;
    logic [15:0] r7_data_q, r7_data_d;

    // BaseR index bits are resolved by the register file, not here.
    logic ir_unused;
    assign ir_unused = ^ir[8:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        sext9_d   = sext9_q;
        sext11_d  = sext11_q;
        base_r_d  = base_r_q;
        nzp_d     = nzp_q;
        link_pc_d = link_pc_q;
        target_d  = target_q;
        r7_data_d = r7_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ir_d      = ir[15:9];
                    sext9_d   = sext9;
                    sext11_d  = sext11;
                    base_r_d  = base_r;
                    nzp_d     = nzp;
                    link_pc_d = pc_q;
                    state_d   = S_EVAL;
                end else if (inc) begin
                    pc_d = pc_q + 16'd1;
                end
            end
            S_EVAL: begin
                state_d = S_DONE;
                case (ir_q[6:3])
                    OP_BR: begin
                        if ((ir_q[2:0] & nzp_q) != 3'b000) begin
                            pc_d = link_pc_q + sext9_q;
                        end
                    end
                    OP_JMP: pc_d = base_r_q;
                    OP_JSR: begin
                        // Target latched before R7 is written so JSRR R7 uses the old R7.
                        target_d  = ir_q[2] ? (link_pc_q + sext11_q) : base_r_q;
                        r7_data_d = link_pc_q;
                        state_d   = S_LINK;
                    end
                    default: ;
                endcase
            end
            S_LINK: begin
                pc_d    = target_q;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            sext9_q   <= '0;
            sext11_q  <= '0;
            base_r_q  <= '0;
            nzp_q     <= '0;
            link_pc_q <= '0;
            target_q  <= '0;
            r7_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            sext9_q   <= sext9_d;
            sext11_q  <= sext11_d;
            base_r_q  <= base_r_d;
            nzp_q     <= nzp_d;
            link_pc_q <= link_pc_d;
            target_q  <= target_d;
            r7_data_q <= r7_data_d;
        end
    end

    assign pc      = pc_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign r7_we   = (state_q == S_LINK);
    assign r7_data = r7_data_q;

endmodule

// File: tb/tb_lc3_pc_unit.sv
// Directed bench for lc3_pc_unit: vector table of control-flow ops plus
// hand sequences for increment, start/inc collision and reset mid-link.
module tb_lc3_pc_unit;

    logic        clk = 1'b0;
    logic        rst, inc, start;
    logic [15:0] ir, sext9, sext11, base_r;
    logic [2:0]  nzp;
    logic [15:0] pc, r7_data;
    logic        busy, done, r7_we;

    int checks = 0;
    int errors = 0;
    logic [15:0] cur_pc;

    always #5 clk = ~clk;

    lc3_pc_unit #(.RESET_PC(16'h3000)) dut (
        .clk(clk), .rst(rst), .inc(inc), .start(start), .ir(ir),
        .sext9(sext9), .sext11(sext11), .base_r(base_r), .nzp(nzp),
        .pc(pc), .busy(busy), .done(done), .r7_we(r7_we), .r7_data(r7_data)
    );

    typedef struct {
        string       name;
        logic [15:0] pc0;
        logic [15:0] ir;
        logic [15:0] s9;
        logic [15:0] s11;
        logic [15:0] br;
        logic [2:0]  nzp;
        logic [15:0] exp_pc;
        bit          link;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start one op from IDLE, then check every cycle until back in IDLE.
    task automatic run_op(input string name, input logic [15:0] pc0, input logic [15:0] ir_v,
                          input logic [15:0] s9, input logic [15:0] s11, input logic [15:0] br,
                          input logic [2:0] nzp_v, input logic [15:0] exp_pc, input bit link,
                          input bit with_inc);
        int lat;
        lat = link ? 3 : 2;
        @(posedge clk); #1;
        ir = ir_v; sext9 = s9; sext11 = s11; base_r = br; nzp = nzp_v;
        start = 1'b1; inc = with_inc;
        @(posedge clk); #1;
        start = 1'b0; inc = 1'b1;   // inc while busy must be ignored
        ir = 16'hFFFF; sext9 = 16'hAAAA; sext11 = 16'h5555; base_r = 16'hDEAD; nzp = 3'b111;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk({name, " busy"},  16'(busy),  16'(k <= lat));
            chk({name, " done"},  16'(done),  16'(k == lat));
            chk({name, " r7_we"}, 16'(r7_we), 16'(link && k == 2));
            if (link && k == 2) chk({name, " r7_data"}, r7_data, pc0);
            chk({name, " pc"}, pc, (k < lat) ? pc0 : exp_pc);
            @(posedge clk); #1;
            if (k == lat) inc = 1'b0;
        end
        inc = 1'b0;
    endtask

    task automatic set_pc(input logic [15:0] target);
        run_op("set_pc_jmp", cur_pc, 16'hC000, 16'h0, 16'h0, target, 3'b000, target, 1'b0, 1'b0);
        cur_pc = target;
    endtask

    initial begin
        vecs[0] = '{"br_np_not_taken", 16'h3005, 16'h0A02, 16'h0002, 16'h0000, 16'h0000, 3'b010, 16'h3005, 1'b0};
        vecs[1] = '{"br_z_taken",      16'h3005, 16'h0402, 16'h0002, 16'h0000, 16'h0000, 3'b010, 16'h3007, 1'b0};
        vecs[2] = '{"br_never",        16'h3005, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 3'b111, 16'h3005, 1'b0};
        vecs[3] = '{"br_n_back",       16'h3000, 16'h0800, 16'hFFF0, 16'h0000, 16'h0000, 3'b100, 16'h2FF0, 1'b0};
        vecs[4] = '{"jsr",             16'h3005, 16'h4FFE, 16'h0000, 16'hFFFE, 16'h0000, 3'b000, 16'h3003, 1'b1};
        vecs[5] = '{"jsrr_r7",         16'h3010, 16'h41C0, 16'h0000, 16'h0000, 16'h4000, 3'b000, 16'h4000, 1'b1};
        vecs[6] = '{"ret",             16'h4000, 16'hC1C0, 16'h0000, 16'h0000, 16'h1234, 3'b000, 16'h1234, 1'b0};
        vecs[7] = '{"other_opcode",    16'h1234, 16'h1042, 16'h0007, 16'h0009, 16'h2222, 3'b111, 16'h1234, 1'b0};
        vecs[8] = '{"br_nzp_wrap",     16'hFFFF, 16'h0E01, 16'h0001, 16'h0000, 16'h0000, 3'b001, 16'h0000, 1'b0};

        rst = 1'b1; inc = 1'b0; start = 1'b0;
        ir = '0; sext9 = '0; sext11 = '0; base_r = '0; nzp = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset pc",      pc,           16'h3000);
        chk("reset busy",    16'(busy),    16'h0);
        chk("reset done",    16'(done),    16'h0);
        chk("reset r7_we",   16'(r7_we),   16'h0);
        chk("reset r7_data", r7_data,      16'h0);

        @(posedge clk); #1;
        inc = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("inc busy", 16'(busy), 16'h0);
            chk("inc done", 16'(done), 16'h0);
            @(posedge clk); #1;
        end
        inc = 1'b0;
        @(negedge clk);
        chk("inc x3 pc", pc, 16'h3003);
        cur_pc = 16'h3003;

        for (int i = 0; i < 9; i++) begin
            set_pc(vecs[i].pc0);
            run_op(vecs[i].name, vecs[i].pc0, vecs[i].ir, vecs[i].s9, vecs[i].s11,
                   vecs[i].br, vecs[i].nzp, vecs[i].exp_pc, vecs[i].link, 1'b0);
            cur_pc = vecs[i].exp_pc;
        end

        // start and inc together right after the wrap: no increment may leak in
        run_op("start_and_inc", 16'h0000, 16'h1000, 16'h0, 16'h0, 16'h0, 3'b000,
               16'h0000, 1'b0, 1'b1);

        // reset asserted while in LINK abandons the link write
        set_pc(16'h3005);
        @(posedge clk); #1;
        ir = 16'h4FFE; sext11 = 16'hFFFE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; inc = 1'b1;
        @(negedge clk);
        chk("rstlink eval busy", 16'(busy), 16'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstlink r7_we",   16'(r7_we), 16'h1);
        chk("rstlink r7_data", r7_data,    16'h3005);
        chk("rstlink hold pc", pc,         16'h3005);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; inc = 1'b0;
        @(negedge clk);
        chk("rstlink pc",      pc,         16'h3000);
        chk("rstlink r7_we 0", 16'(r7_we), 16'h0);
        chk("rstlink busy",    16'(busy),  16'h0);
        chk("rstlink done",    16'(done),  16'h0);
        chk("rstlink r7_data", r7_data,    16'h0);
        @(negedge clk);
        chk("rstlink stays idle", 16'(busy | done | r7_we), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
